// File: rtl/conv_accum_sched.sv
// Convolution accumulation scheduler: feeds operand groups one at a time through the shared adder
// tree, accumulates bias plus group sums, then saturates. Define SCHED_RELU_EN to add a ReLU stage.
module conv_accum_sched #(
   parameter int unsigned BITSIZE    = 14,
   parameter int unsigned NUM_INPUTS = 27,
   parameter int unsigned GRP_W      = 4,
   parameter int unsigned ACC_WIDTH  = 20
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_start,
   input  logic [GRP_W-1:0]              cfg_groups,
   input  logic [BITSIZE-1:0]            cfg_bias,
   output logic                          busy,
   input  logic [NUM_INPUTS*BITSIZE-1:0] grp_data,
   input  logic                          grp_valid,
   output logic                          grp_ready,
   output logic [NUM_INPUTS*BITSIZE-1:0] adder_in,
   output logic                          adder_start,
   input  logic [BITSIZE-1:0]            adder_sum,
   input  logic                          adder_valid,
   output logic [BITSIZE-1:0]            out_data,
   output logic                          out_valid,
   input  logic                          out_ready
);

   typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StFinal, StOut} state_e;

   localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'((1 << (BITSIZE - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;

   state_e                        state_q, state_d;
   logic [GRP_W-1:0]              groups_q, groups_d;
   logic [GRP_W-1:0]              grp_cnt_q, grp_cnt_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [NUM_INPUTS*BITSIZE-1:0] adder_in_q, adder_in_d;
   logic [BITSIZE-1:0]            out_data_q, out_data_d;

   logic signed [ACC_WIDTH-1:0]   bias_ext, sum_ext, acc_sat;
   logic [BITSIZE-1:0]            result;

   assign bias_ext = {{(ACC_WIDTH - BITSIZE){cfg_bias[BITSIZE-1]}}, cfg_bias};
   assign sum_ext  = {{(ACC_WIDTH - BITSIZE){adder_sum[BITSIZE-1]}}, adder_sum};

   always_comb begin
      if (acc_q > SatMax) begin
         acc_sat = SatMax;
      end else if (acc_q < SatMin) begin
         acc_sat = SatMin;
      end else begin
         acc_sat = acc_q;
      end
      result = acc_sat[BITSIZE-1:0];
`ifdef SCHED_RELU_EN
      if (acc_sat[ACC_WIDTH-1]) begin
         result = '0;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      groups_d    = groups_q;
      grp_cnt_d   = grp_cnt_q;
      acc_d       = acc_q;
      adder_in_d  = adder_in_q;
      out_data_d  = out_data_q;
      grp_ready   = 1'b0;
      adder_start = 1'b0;
      out_valid   = 1'b0;
      busy        = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (job_start) begin
               groups_d  = cfg_groups;
               acc_d     = bias_ext;
               grp_cnt_d = '0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            grp_ready = 1'b1;
            if (grp_valid) begin
               adder_in_d = grp_data;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            adder_start = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            // Single group in flight, so each adder result closes out the current group.
            if (adder_valid) begin
               acc_d = acc_q + sum_ext;
               if (grp_cnt_q == groups_q) begin
                  state_d = StFinal;
               end else begin
                  grp_cnt_d = grp_cnt_q + GRP_W'(1);
                  state_d   = StLoad;
               end
            end
         end
         StFinal: begin
            out_data_d = result;
            state_d    = StOut;
         end
         StOut: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         groups_q   <= '0;
         grp_cnt_q  <= '0;
         acc_q      <= '0;
         adder_in_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         groups_q   <= groups_d;
         grp_cnt_q  <= grp_cnt_d;
         acc_q      <= acc_d;
         adder_in_q <= adder_in_d;
         out_data_q <= out_data_d;
      end
   end

   assign adder_in = adder_in_q;
   assign out_data = out_data_q;

endmodule
